chunk_add_seq: RTL and testbench
================================

CHUNK_ADD_SEQ -- requirements
Module: chunk_add_seq

Interface
REQ-001 Parameter: NUM_NIBBLES, 4, number of 4-bit chunks per operand; operand width W = 4*NUM_NIBBLES; legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream offers an operand pair.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 in_a  input  W  operand A.
REQ-007 in_b  input  W  operand B.
REQ-008 in_cin  input  1  carry-in for the full W-bit add.
REQ-009 adder_a  output  4  nibble of A driven to the external 4-bit full adder.
REQ-010 adder_b  output  4  nibble of B driven to the external 4-bit full adder.
REQ-011 adder_cin  output  1  carry driven to the external adder.
REQ-012 adder_sum  input  4  combinational sum returned by the external adder.
REQ-013 adder_cout  input  1  combinational carry-out returned by the external adder.
REQ-014 out_valid  output  1  result available.
REQ-015 out_ready  input  1  downstream accepts the result.
REQ-016 out_sum  output  W  W-bit sum.
REQ-017 out_cout  output  1  final carry-out.
REQ-018 busy  output  1  high when state is not IDLE.

Function
REQ-019 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-020 in_ready SHALL be 1 only in IDLE; busy SHALL be 1 only in RUN or DONE; out_valid SHALL be 1 only in DONE; all SHALL be decoded from registered state.
REQ-021 IDLE: on in_valid && in_ready at a posedge, the block SHALL register in_a, in_b, and in_cin (into the carry register), clear the nibble index to 0, clear the sum register, and enter RUN.
REQ-022 RUN: adder_a/adder_b SHALL equal nibble[idx] (bits 4*idx+3..4*idx) of the registered A/B, and adder_cin SHALL equal the carry register.
REQ-023 RUN, each posedge: the block SHALL write adder_sum into sum nibble[idx], load adder_cout into the carry register, and increment idx.
REQ-024 RUN with idx == NUM_NIBBLES-1 at a posedge: after the capture in REQ-023, the block SHALL enter DONE; idx SHALL NOT wrap into an extra capture.
REQ-025 Latency: out_valid SHALL rise exactly NUM_NIBBLES cycles after the accepting posedge (4 for the default).
REQ-026 DONE: out_sum SHALL equal the sum register, out_cout SHALL equal the carry register, and both SHALL be held stable until the handshake completes.
REQ-027 DONE with out_ready == 1 at a posedge: the block SHALL enter IDLE; with out_ready == 0 it SHALL stay in DONE indefinitely.
REQ-028 in_valid SHALL be ignored in RUN and DONE; no operand is captured and no state changes.
REQ-029 A new operand SHALL NOT be accepted in the same cycle as the result handoff; the minimum issue interval is NUM_NIBBLES+2 cycles.
REQ-030 Outside RUN, adder_a, adder_b and adder_cin SHALL be driven to 0.
REQ-031 out_sum and out_cout SHALL be 0 outside DONE.
REQ-032 Arithmetic SHALL be unsigned: {out_cout, out_sum} == in_a + in_b + in_cin, modulo 2^(W+1).

Reset
REQ-033 reset_n low SHALL immediately, without waiting for clk, force: state IDLE, idx 0, carry 0, operand and sum registers 0.
REQ-034 While reset_n is low: in_ready = 1; busy = 0; out_valid = 0; out_sum = 0; out_cout = 0; adder_* = 0.
REQ-035 Reset asserted mid-RUN or mid-DONE SHALL abort the operation, and no partial result SHALL appear after release.
REQ-036 After reset_n rises, the first posedge with in_valid high SHALL be accepted normally.

Verification
REQ-037 Basic add: A=0x1234, B=0x4321, cin=0 -> out_valid 4 cycles after accept; out_sum=0x5555, out_cout=0; adder_a sequence 4,3,2,1.
REQ-038 Full ripple: A=0xFFFF, B=0x0001, cin=0 -> out_sum=0x0000, out_cout=1; adder_cin sequence 0,1,1,1.
REQ-039 All-ones: A=0xFFFF, B=0xFFFF, cin=1 -> out_sum=0xFFFF, out_cout=1.
REQ-040 Backpressure: hold out_ready=0 for 3 cycles in DONE and pulse in_valid with A=0x0F0F -> out_valid stays 1, out_sum is unchanged, in_ready=0, and the new operand is not captured; IDLE is entered one posedge after out_ready=1.
REQ-041 Reset mid-operation: start A=0x00FF, B=0x0001, and drop reset_n after 2 RUN cycles -> all outputs go to their reset values immediately (no clock edge needed); after release, 0x0001+0x0001 yields 0x0002, cout 0.
REQ-042 Ignored input: assert in_valid continuously with changing operands during RUN -> the result reflects only the operands captured at the accepting edge.

Source files
------------

// File: rtl/chunk_add_seq_if.sv
// Bundle of the operand stream, result stream and external 4-bit adder
// signals for chunk_add_seq; the slave modport is the sequencer's view.
interface chunk_add_seq_if #(
  parameter int NUM_NIBBLES = 4
);
  localparam int W = 4 * NUM_NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;

  logic [3:0]   adder_a;
  logic [3:0]   adder_b;
  logic         adder_cin;
  logic [3:0]   adder_sum;
  logic         adder_cout;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;

  logic         busy;

  modport slave (
    input  in_valid, in_a, in_b, in_cin,
    input  adder_sum, adder_cout,
    input  out_ready,
    output in_ready,
    output adder_a, adder_b, adder_cin,
    output out_valid, out_sum, out_cout,
    output busy
  );

  modport master (
    output in_valid, in_a, in_b, in_cin,
    output adder_sum, adder_cout,
    output out_ready,
    input  in_ready,
    input  adder_a, adder_b, adder_cin,
    input  out_valid, out_sum, out_cout,
    input  busy
  );
endinterface

// File: rtl/chunk_add_seq.sv
// Sequential W-bit adder that reuses one external 4-bit full adder,
// rippling the carry through one nibble per clock, LSB first.
module chunk_add_seq #(
  parameter int NUM_NIBBLES = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  chunk_add_seq_if.slave  bus
);
  localparam int W     = 4 * NUM_NIBBLES;
  localparam int IDX_W = $clog2(NUM_NIBBLES);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     sum_reg;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic             in_run;
  logic             in_done;

  assign in_run  = (state == RUN);
  assign in_done = (state == DONE);

  // {idx,2'b00} is the bit offset 4*idx of the active nibble.
  assign a_nib = a_reg[{idx, 2'b00} +: 4];
  assign b_nib = b_reg[{idx, 2'b00} +: 4];

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = in_done;

  assign bus.adder_a   = in_run ? a_nib : 4'h0;
  assign bus.adder_b   = in_run ? b_nib : 4'h0;
  assign bus.adder_cin = in_run & carry;

  assign bus.out_sum   = in_done ? sum_reg : '0;
  assign bus.out_cout  = in_done & carry;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg   <= bus.in_a;
            b_reg   <= bus.in_b;
            carry   <= bus.in_cin;
            idx     <= '0;
            sum_reg <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_reg[{idx, 2'b00} +: 4] <= bus.adder_sum;
          carry                      <= bus.adder_cout;
          // The last nibble parks idx so no extra capture can follow.
          if (idx == IDX_W'(NUM_NIBBLES - 1)) begin
            state <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_chunk_add_seq.sv
// Randomized self-checking bench for chunk_add_seq; models the external
// 4-bit adder and predicts results with plain wide arithmetic.
module tb_chunk_add_seq;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  chunk_add_seq_if #(.NUM_NIBBLES(N)) bus ();

  assign {bus.adder_cout, bus.adder_sum} =
    {1'b0, bus.adder_a} + {1'b0, bus.adder_b} + {4'b0000, bus.adder_cin};

  chunk_add_seq #(.NUM_NIBBLES(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int           tests_run;
  int           tests_failed;
  logic [W-1:0] obs_sum;
  logic         obs_cout;
  int           obs_lat;
  logic [3:0]   seq_a [N];
  logic         seq_cin [N];

  function automatic logic [W:0] ref_add(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + (W+1)'(c);
  endfunction

  task automatic jiggle_inputs();
    bus.in_valid = 1'b1;
    bus.in_a     = W'($urandom);
    bus.in_b     = W'($urandom);
    bus.in_cin   = 1'($urandom);
  endtask

  // Issues one operand pair and collects the result; with noise set, in_valid
  // stays high with fresh junk operands every cycle after the accept.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input int ready_delay, input bit noise);
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_cin    = c;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (noise) jiggle_inputs();
    else bus.in_valid = 1'b0;
    obs_lat = 0;
    while (!bus.out_valid && obs_lat < 50) begin
      if (obs_lat < N) begin
        seq_a[obs_lat]   = bus.adder_a;
        seq_cin[obs_lat] = bus.adder_cin;
      end
      @(posedge clk);
      @(negedge clk);
      obs_lat++;
      if (noise) jiggle_inputs();
    end
    obs_sum  = bus.out_sum;
    obs_cout = bus.out_cout;
    repeat (ready_delay) begin
      @(posedge clk);
      @(negedge clk);
      if (noise) jiggle_inputs();
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 16'hABCD;
    bus.in_b      = 16'h1111;
    bus.in_cin    = 1'b1;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got ready/busy/valid=%b required 100",
               {bus.in_ready, bus.busy, bus.out_valid});
    end
    tests_run++;
    if ({bus.out_cout, bus.out_sum} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_out: got %h required 0", {bus.out_cout, bus.out_sum});
    end
    tests_run++;
    if ({bus.adder_a, bus.adder_b, bus.adder_cin} !== 9'h000) begin
      tests_failed++;
      $display("[TB] FAIL reset_adder: got %h required 000",
               {bus.adder_a, bus.adder_b, bus.adder_cin});
    end
    bus.in_valid = 1'b0;
    reset_n      = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [3:0] exp_a [N];
    exp_a = '{4'h4, 4'h3, 4'h2, 4'h1};
    run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
    tests_run++;
    if (obs_lat !== N) begin
      tests_failed++;
      $display("[TB] FAIL basic_latency: got %0d required %0d", obs_lat, N);
    end
    tests_run++;
    if ({obs_cout, obs_sum} !== 17'h05555) begin
      tests_failed++;
      $display("[TB] FAIL basic_sum: got %h required 05555", {obs_cout, obs_sum});
    end
    for (int i = 0; i < N; i++) begin
      tests_run++;
      if (seq_a[i] !== exp_a[i]) begin
        tests_failed++;
        $display("[TB] FAIL basic_adder_a[%0d]: got %h required %h", i, seq_a[i], exp_a[i]);
      end
    end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL basic_idle: got in_ready %b required 1", bus.in_ready);
    end
  endtask

  task automatic test_ripple();
    logic exp_c [N];
    exp_c = '{1'b0, 1'b1, 1'b1, 1'b1};
    run_op(16'hFFFF, 16'h0001, 1'b0, 1, 1'b0);
    tests_run++;
    if ({obs_cout, obs_sum} !== 17'h10000) begin
      tests_failed++;
      $display("[TB] FAIL ripple_sum: got %h required 10000", {obs_cout, obs_sum});
    end
    for (int i = 0; i < N; i++) begin
      tests_run++;
      if (seq_cin[i] !== exp_c[i]) begin
        tests_failed++;
        $display("[TB] FAIL ripple_cin[%0d]: got %b required %b", i, seq_cin[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_all_ones();
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0);
    tests_run++;
    if ({obs_cout, obs_sum} !== 17'h1FFFF) begin
      tests_failed++;
      $display("[TB] FAIL all_ones_sum: got %h required 1ffff", {obs_cout, obs_sum});
    end
  endtask

  task automatic test_backpressure();
    int guard;
    bus.in_a      = 16'h1234;
    bus.in_b      = 16'h4321;
    bus.in_cin    = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 50) begin
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 16'h0F0F;
      bus.in_b     = 16'h0F0F;
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if ({bus.out_valid, bus.in_ready, bus.out_cout, bus.out_sum} !== {2'b10, 17'h05555}) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold[%0d]: got valid/ready=%b%b sum=%h required 10 05555",
                 k, bus.out_valid, bus.in_ready, {bus.out_cout, bus.out_sum});
      end
    end
    tests_run++;
    if (bus.adder_a !== 4'h0) begin
      tests_failed++;
      $display("[TB] FAIL bp_adder_idle: got %h required 0", bus.adder_a);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    tests_run++;
    if ({bus.out_valid, bus.busy, bus.in_ready, bus.out_sum} !== {3'b001, 16'h0000}) begin
      tests_failed++;
      $display("[TB] FAIL bp_release: got valid/busy/ready=%b sum=%h required 001 0000",
               {bus.out_valid, bus.busy, bus.in_ready}, bus.out_sum);
    end
  endtask

  task automatic test_reset_mid();
    int valid_seen;
    bus.in_a      = 16'h00FF;
    bus.in_b      = 16'h0001;
    bus.in_cin    = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    tests_run++;
    if ({bus.busy, bus.adder_cin} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL mid_before: got busy/cin=%b required 11", {bus.busy, bus.adder_cin});
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.in_ready, bus.busy, bus.out_valid, bus.adder_cin, bus.adder_a, bus.adder_b}
        !== {4'b1000, 8'h00}) begin
      tests_failed++;
      $display("[TB] FAIL mid_async: got %b required 100000000000",
               {bus.in_ready, bus.busy, bus.out_valid, bus.adder_cin, bus.adder_a, bus.adder_b});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    valid_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy) valid_seen++;
    end
    tests_run++;
    if (valid_seen !== 0) begin
      tests_failed++;
      $display("[TB] FAIL mid_no_partial: got %0d active cycles required 0", valid_seen);
    end
    run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0);
    tests_run++;
    if ({obs_cout, obs_sum} !== 17'h00002 || obs_lat !== N) begin
      tests_failed++;
      $display("[TB] FAIL mid_after: got sum %h lat %0d required 00002 lat %0d",
               {obs_cout, obs_sum}, obs_lat, N);
    end
  endtask

  task automatic test_ignored_input();
    logic [W-1:0] a, b;
    logic         c;
    for (int t = 0; t < 4; t++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = 1'($urandom);
      run_op(a, b, c, t % 3, 1'b1);
      tests_run++;
      if ({obs_cout, obs_sum} !== ref_add(a, b, c)) begin
        tests_failed++;
        $display("[TB] FAIL ignored_sum[%0d]: got %h required %h", t,
                 {obs_cout, obs_sum}, ref_add(a, b, c));
      end
      tests_run++;
      if (bus.busy !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL ignored_handoff[%0d]: got busy %b required 0", t, bus.busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2;
    logic         c1, c2;
    int           edges, guard;
    a1 = W'($urandom); b1 = W'($urandom); c1 = 1'($urandom);
    a2 = W'($urandom); b2 = W'($urandom); c2 = 1'($urandom);
    bus.in_a = a1; bus.in_b = b1; bus.in_cin = c1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    edges = 0;
    @(negedge clk);
    bus.in_a = a2; bus.in_b = b2; bus.in_cin = c2;
    while (!bus.out_valid && edges < 50) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    tests_run++;
    if ({bus.out_cout, bus.out_sum} !== ref_add(a1, b1, c1)) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: got %h required %h", {bus.out_cout, bus.out_sum},
               ref_add(a1, b1, c1));
    end
    @(posedge clk);
    edges++;
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_handoff_accept: got busy %b required 0", bus.busy);
    end
    @(posedge clk);
    edges++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b1 || edges !== N + 2) begin
      tests_failed++;
      $display("[TB] FAIL b2b_interval: got busy %b interval %0d required 1 %0d",
               bus.busy, edges, N + 2);
    end
    guard = 0;
    while (!bus.out_valid && guard < 50) begin
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    tests_run++;
    if ({bus.out_cout, bus.out_sum} !== ref_add(a2, b2, c2)) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: got %h required %h", {bus.out_cout, bus.out_sum},
               ref_add(a2, b2, c2));
    end
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         c;
    for (int t = 0; t < 25; t++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = 1'($urandom);
      run_op(a, b, c, $urandom_range(0, 3), 1'b0);
      tests_run++;
      if ({obs_cout, obs_sum} !== ref_add(a, b, c) || obs_lat !== N) begin
        tests_failed++;
        $display("[TB] FAIL random[%0d]: %h+%h+%b got %h lat %0d required %h lat %0d",
                 t, a, b, c, {obs_cout, obs_sum}, obs_lat, ref_add(a, b, c), N);
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_ripple();
    test_all_ones();
    test_backpressure();
    test_reset_mid();
    test_ignored_input();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
